// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator command path: token codes,
// command opcodes, error codes, FSM state encoding, and a small helper.
package calc_pkg;

  // Decoder token codes
  localparam logic [3:0] DIG_MAX      = 4'd9;
  localparam logic [3:0] TOK_SIN      = 4'd12;
  localparam logic [3:0] TOK_COS      = 4'd13;
  localparam logic [3:0] TOK_SQUARE   = 4'd14;
  localparam logic [3:0] TOK_IS_PRIME = 4'd15;

  // Operation handed to the compute unit; matches the low two bits of the
  // operator token code, so the conversion is a simple slice.
  typedef enum logic [1:0] {
    OP_SIN      = 2'd0,
    OP_COS      = 2'd1,
    OP_SQUARE   = 2'd2,
    OP_IS_PRIME = 2'd3
  } cmd_op_e;

  // Error codes reported on the one-cycle error pulse
  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_INVALID    = 3'd1,
    ERR_OVERFLOW   = 3'd2,
    ERR_NO_OPERAND = 3'd3,
    ERR_BUSY       = 3'd4
  } err_code_e;

  // Command assembler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // 10**n as a constant function, used for parameter sanity checks
  function automatic longint pow10(input int n);
    longint r;
    r = 64'sd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'sd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Three-flop synchroniser for an asynchronous strobe level plus a rising-edge
// detector on the synchronised copy. One event per rising edge of strobe_i.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic evt_o
);

  logic s1_q, s2_q, s3_q;

  // Shift the raw strobe through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= strobe_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s2 is the first metastability-safe copy; s3 is its one-cycle delay
  assign evt_o = s2_q & ~s3_q;

endmodule

// File: rtl/calc_cmd_assembler.sv
// Assembles postfix calculator commands (decimal digits followed by one
// operator token) from decoder tokens and issues {op, operand} over a
// valid/ready handshake. Malformed input is reported as one-cycle error pulses.
module calc_cmd_assembler
  import calc_pkg::*;
#(
  parameter int OPERAND_W  = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tok_strobe,
  input  logic [3:0]           tok_code,
  input  logic                 tok_is_number,
  input  logic                 tok_is_valid,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [1:0]           cmd_op,
  output logic [OPERAND_W-1:0] cmd_operand,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic                 busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  // The largest MAX_DIGITS-digit decimal number must fit in the operand so
  // acc*10+digit never wraps.
  if (OPERAND_W < 1 || OPERAND_W > 62 || MAX_DIGITS < 1 ||
      (pow10(MAX_DIGITS) - 64'sd1) >= (64'sd1 <<< OPERAND_W)) begin : g_bad_params
    $error("calc_cmd_assembler: 10**MAX_DIGITS-1 does not fit in OPERAND_W bits");
  end

  logic tok_evt;

  strobe_sync u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (tok_strobe),
    .evt_o    (tok_evt)
  );

  state_e                 state_q, state_d;
  logic [OPERAND_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cmd_valid_q, cmd_valid_d;
  cmd_op_e                cmd_op_q, cmd_op_d;
  logic [OPERAND_W-1:0]   operand_q, operand_d;
  logic                   err_valid_q, err_valid_d;
  err_code_e              err_code_q, err_code_d;

  logic is_digit, is_op;

  // Token classification; anything neither digit nor operator is bad
  assign is_digit = tok_is_valid & tok_is_number;
  assign is_op    = tok_is_valid & ~tok_is_number & (tok_code >= TOK_SIN);

  // State, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_SIN;
      operand_q   <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      operand_q   <= operand_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  // Next-state logic: token handling per state and the issue handshake
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    operand_d   = operand_q;
    err_valid_d = 1'b0;
    err_code_d  = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (tok_evt) begin
          if (is_digit) begin
            acc_d   = OPERAND_W'(tok_code);
            cnt_d   = CNT_W'(1);
            state_d = ST_ACCUM;
          end else if (is_op) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_NO_OPERAND;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_INVALID;
          end
        end
      end

      ST_ACCUM: begin
        if (tok_evt) begin
          if (is_digit) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
              acc_d = acc_q * OPERAND_W'(10) + OPERAND_W'(tok_code);
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_OVERFLOW;
              acc_d       = '0;
              cnt_d       = '0;
              state_d     = ST_IDLE;
            end
          end else if (is_op) begin
            operand_d   = acc_q;
            cmd_op_d    = cmd_op_e'(tok_code[1:0]);
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_INVALID;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_ISSUE: begin
        // Tokens arriving while a command is pending are dropped, even in the
        // handshake cycle itself.
        if (tok_evt) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_BUSY;
        end
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_operand = operand_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_cmd_assembler.sv
// Directed scoreboard bench for calc_cmd_assembler: stimulus pushes expected
// commands/errors into queues, a monitor pops and compares on DUT output.
module tb_calc_cmd_assembler;

  logic        clk;
  logic        rst_n;
  logic        tok_strobe;
  logic [3:0]  tok_code;
  logic        tok_is_number;
  logic        tok_is_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_operand;
  logic        err_valid;
  logic [2:0]  err_code;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] exp_cmd_q[$];
  logic [2:0]  exp_err_q[$];

  calc_cmd_assembler #(.OPERAND_W(16), .MAX_DIGITS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tok_strobe    (tok_strobe),
    .tok_code      (tok_code),
    .tok_is_number (tok_is_number),
    .tok_is_valid  (tok_is_valid),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_operand   (cmd_operand),
    .err_valid     (err_valid),
    .err_code      (err_code),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [15:0] operand);
    exp_cmd_q.push_back({op, operand});
  endtask

  task automatic push_err(input logic [2:0] code);
    exp_err_q.push_back(code);
  endtask

  // Decoder-like token: data set with the strobe edge, held while strobe high
  task automatic send_tok(input logic [3:0] code, input logic num, input logic vld);
    @(negedge clk);
    tok_code      = code;
    tok_is_number = num;
    tok_is_valid  = vld;
    tok_strobe    = 1'b1;
    repeat (4) @(negedge clk);
    tok_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] d);
    send_tok(d, 1'b1, 1'b1);
  endtask

  task automatic opk(input logic [3:0] c);
    send_tok(c, 1'b0, 1'b1);
  endtask

  task automatic wait_cmd_valid(input string name);
    int k;
    k = 0;
    while (!cmd_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!cmd_valid) begin
      n_bad++;
      $display("FAIL %s: cmd_valid got 0 after %0d cycles, required 1", name, k);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"},   {31'd0, cmd_valid}, 32'd0);
    check({tag, "_cmd_op"},      {30'd0, cmd_op}, 32'd0);
    check({tag, "_cmd_operand"}, {16'd0, cmd_operand}, 32'd0);
    check({tag, "_err_valid"},   {31'd0, err_valid}, 32'd0);
    check({tag, "_err_code"},    {29'd0, err_code}, 32'd0);
    check({tag, "_busy"},        {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compare every handshake and every error pulse against the queues
  logic [17:0] mon_cmd;
  logic [2:0]  mon_err;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cmd: got op=%0d operand=%0d, required no command", cmd_op, cmd_operand);
        end else begin
          mon_cmd = exp_cmd_q.pop_front();
          check("cmd_op", {30'd0, cmd_op}, {30'd0, mon_cmd[17:16]});
          check("cmd_operand", {16'd0, cmd_operand}, {16'd0, mon_cmd[15:0]});
          $display("cmd op=%0d operand=%0d", cmd_op, cmd_operand);
        end
      end
      if (err_valid) begin
        if (exp_err_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_err: got err_code=%0d, required no error", err_code);
        end else begin
          mon_err = exp_err_q.pop_front();
          check("err_code", {29'd0, err_code}, {29'd0, mon_err});
          $display("err code=%0d", err_code);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    tok_strobe    = 1'b0;
    tok_code      = 4'd0;
    tok_is_number = 1'b0;
    tok_is_valid  = 1'b0;
    cmd_ready     = 1'b0;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1) "123" SQUARE with ready high, latency of the operator token
    cmd_ready = 1'b1;
    dig(4'd1);
    dig(4'd2);
    dig(4'd3);
    check("accum_busy", {31'd0, busy}, 32'd1);
    push_cmd(2'd2, 16'd123);
    @(negedge clk);
    tok_code = 4'd14; tok_is_number = 1'b0; tok_is_valid = 1'b1; tok_strobe = 1'b1;
    @(posedge clk); #1 check("lat_edge1", {31'd0, cmd_valid}, 32'd0);
    @(posedge clk); #1 check("lat_edge2", {31'd0, cmd_valid}, 32'd0);
    @(posedge clk); #1 check("lat_edge3", {31'd0, cmd_valid}, 32'd1);
    check("issue_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 check("pulse_end", {31'd0, cmd_valid}, 32'd0);
    check("idle_after_hs", {31'd0, busy}, 32'd0);
    @(negedge clk);
    tok_strobe = 1'b0;
    repeat (3) @(negedge clk);

    // 2) "9999" SIN with ready low; a digit during the wait is BUSY
    cmd_ready = 1'b0;
    dig(4'd9); dig(4'd9); dig(4'd9); dig(4'd9);
    opk(4'd12);
    wait_cmd_valid("wait_9999");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, cmd_valid}, 32'd1);
      check("hold_op", {30'd0, cmd_op}, 32'd0);
      check("hold_operand", {16'd0, cmd_operand}, 32'd9999);
      @(negedge clk);
    end
    push_err(3'd4);
    dig(4'd5);
    check("busy_hold_valid", {31'd0, cmd_valid}, 32'd1);
    check("busy_hold_operand", {16'd0, cmd_operand}, 32'd9999);
    push_cmd(2'd0, 16'd9999);
    @(posedge clk); #1 cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("drop_after_hs", {31'd0, cmd_valid}, 32'd0);

    // 3) five digits overflow, then "7" COS
    dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
    push_err(3'd2);
    dig(4'd5);
    check("ovf_busy", {31'd0, busy}, 32'd0);
    dig(4'd7);
    push_cmd(2'd1, 16'd7);
    opk(4'd13);

    // 4) operator with no operand, then invalid token clears "4"
    push_err(3'd3);
    opk(4'd15);
    check("noop_no_cmd", {31'd0, cmd_valid}, 32'd0);
    dig(4'd4);
    push_err(3'd1);
    send_tok(4'd4, 1'b1, 1'b0);
    check("inv_busy", {31'd0, busy}, 32'd0);
    dig(4'd6);
    push_cmd(2'd2, 16'd6);
    opk(4'd14);
    // valid code 10 that is not a number is also invalid
    push_err(3'd1);
    send_tok(4'd10, 1'b0, 1'b1);

    // 5) asynchronous reset mid-ACCUM and mid-ISSUE
    dig(4'd5);
    dig(4'd6);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_accum");
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b0;
    dig(4'd9);
    opk(4'd13);
    wait_cmd_valid("wait_pre_rst_issue");
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_issue");
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    dig(4'd8);
    push_cmd(2'd0, 16'd8);
    opk(4'd12);

    // 6) strobe held high, then toggling every 2 cycles: one event per edge
    @(negedge clk);
    tok_code = 4'd3; tok_is_number = 1'b1; tok_is_valid = 1'b1; tok_strobe = 1'b1;
    repeat (20) @(negedge clk);
    tok_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("held_high_busy", {31'd0, busy}, 32'd1);
    for (int d = 4; d <= 5; d++) begin
      @(negedge clk);
      tok_code = 4'(d);
      tok_strobe = 1'b1;
      repeat (2) @(negedge clk);
      tok_strobe = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    push_cmd(2'd2, 16'd345);
    opk(4'd14);

    // Everything expected must have been observed
    repeat (5) @(negedge clk);
    check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
    check("err_queue_drained", exp_err_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end

endmodule
